button_conditioner: RTL and testbench

- Input stage for the clock/calendar counter. Conditions the three raw push-buttons: increase, decrease and change.
- Per button: 2-FF synchroniser, debounce, press-edge detection, and auto-repeat on held increase/decrease.
- Keeps the edit-field selector cycled by the change button.
- Emits single-cycle inc/dec pulses, qualified by the selected field, for the downstream time/date counter.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/button_channel.sv | 197 +++++++++++++++++++
 rtl/button_conditioner.sv | 132 +++++++++++++
 tb/tb_button_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock/calendar front end.
//
// Contents:
//   field_t     - edit-field selector encoding; FIELD_RUN means no field is being edited.
//   btn_state_t - per-button channel FSM states.
//   CLK_HZ      - nominal system clock frequency.
package clock_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  typedef enum logic [2:0] {
    FIELD_RUN   = 3'd0,
    FIELD_SEC   = 3'd1,
    FIELD_MIN   = 3'd2,
    FIELD_HOUR  = 3'd3,
    FIELD_DAY   = 3'd4,
    FIELD_MONTH = 3'd5,
    FIELD_YEAR  = 3'd6
  } field_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

endpackage

// File: rtl/button_channel.sv
// One push-button conditioning channel.
//
// Stages: 2-FF synchroniser -> polarity normalisation (1 = pressed) -> debounce ->
// press-edge detection -> IDLE/HOLD(/REPEAT) FSM.
//
// Ports:
//   clk    - system clock.
//   rst_n  - asynchronous, active-low reset.
//   button - raw, asynchronous button pin.
//   pulse  - one-cycle strobe, combinational from this channel's state. It is high in the
//            cycle just before the clock edge at which the debounced level rises (press) or a
//            repeat interval expires; the parent registers it, so the registered pulse lands
//            DEBOUNCE_CYCLES + 2 clocks after the pin changes.
//
// Parameters:
//   DEBOUNCE_CYCLES     - consecutive differing samples needed to accept a level change.
//   REPEAT_DELAY_CYCLES - hold time from accepted press to the first repeat pulse.
//   REPEAT_RATE_CYCLES  - interval between subsequent repeat pulses (>= 2).
//   REPEAT_ENABLE       - 1: build HOLD/REPEAT with timer; 0: one pulse per press, no timer.
//   ACTIVE_LOW          - 1: pressed pin reads 0.
module button_channel
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 5_000_000,
  parameter bit          REPEAT_ENABLE       = 1'b1,
  parameter bit          ACTIVE_LOW          = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pulse
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  // Pin level when the button is not pressed; the synchroniser resets to it.
  localparam logic Released = ACTIVE_LOW;

  if (REPEAT_ENABLE && (REPEAT_RATE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 2)) begin : g_bad_timing
    $error("button_channel: repeat delay and rate must both be at least 2 cycles");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= Released;
      sync2_q <= Released;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  logic level;
  assign level = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           stable_q, stable_d;

  always_comb begin
    db_cnt_d = '0;
    stable_d = stable_q;
    if (level != stable_q) begin
      if (db_cnt_q == DbLast) begin
        stable_d = ~stable_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
    end
  end

  // High in the cycle the debounced level goes 0 -> 1.
  logic press;
  assign press = stable_d & ~stable_q;

  // ---------------------------------------------------------------------------
  // Channel FSM. It follows stable_d so that it leaves HOLD/REPEAT at the same edge the
  // debounced level drops, which is what keeps the release cycle pulse-free.
  // ---------------------------------------------------------------------------
  btn_state_t state_q, state_d;

  if (REPEAT_ENABLE) begin : g_repeat
    localparam int unsigned TmMax = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned TmW = (TmMax > 1) ? $clog2(TmMax) : 1;
    localparam logic [TmW-1:0] DelayLast = TmW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TmW-1:0] RateLast  = TmW'(REPEAT_RATE_CYCLES - 1);

    logic [TmW-1:0] timer_q, timer_d;
    logic           fsm_pulse;

    always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      fsm_pulse = 1'b0;
      unique case (state_q)
        IDLE: begin
          timer_d = '0;
          if (press) begin
            state_d   = HOLD;
            fsm_pulse = 1'b1;
          end
        end
        HOLD: begin
          if (!stable_d) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == DelayLast) begin
            state_d   = REPEAT;
            timer_d   = '0;
            fsm_pulse = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!stable_d) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == RateLast) begin
            timer_d   = '0;
            fsm_pulse = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
      end
    end

    assign pulse = fsm_pulse;
  end else begin : g_single
    logic fsm_pulse;

    always_comb begin
      state_d   = state_q;
      fsm_pulse = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (press) begin
            state_d   = HOLD;
            fsm_pulse = 1'b1;
          end
        end
        HOLD: begin
          if (!stable_d) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    assign pulse = fsm_pulse;
  end

endmodule

// File: rtl/button_conditioner.sv
// Input stage for the clock/calendar counter: conditions the increase, decrease and change
// push-buttons and keeps the edit-field selector.
//
// Build option:
//   BTN_AUTO_REPEAT_EN - when defined, a held increase/decrease button auto-repeats
//                        (first repeat after REPEAT_DELAY_CYCLES, then every
//                        REPEAT_RATE_CYCLES). When undefined, each accepted press gives exactly
//                        one pulse and no repeat timers are built.
//
// Ports:
//   clk, rst_n     - system clock; asynchronous active-low reset.
//   butt_increase  - raw increase button.
//   butt_decrease  - raw decrease button.
//   butt_change    - raw field-select button.
//   inc_pulse      - one-cycle increment request (only while a field is being edited).
//   dec_pulse      - one-cycle decrement request (only while a field is being edited).
//   chg_pulse      - one-cycle pulse in the cycle field_sel advances.
//   field_sel      - 0 RUN, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year.
//   edit_active    - high when field_sel != RUN.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 5_000_000,
  parameter int unsigned NUM_FIELDS          = 7,
  parameter bit          BUTTON_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       butt_increase,
  input  logic       butt_decrease,
  input  logic       butt_change,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       chg_pulse,
  output logic [2:0] field_sel,
  output logic       edit_active
);

`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AutoRepeat = 1'b1;
`else
  localparam bit AutoRepeat = 1'b0;
`endif

  if (NUM_FIELDS < 2 || NUM_FIELDS > 8) begin : g_bad_fields
    $error("button_conditioner: NUM_FIELDS must be in 2..8");
  end

  localparam field_t LastField = field_t'(3'(NUM_FIELDS - 1));

  logic inc_raw, dec_raw, chg_raw;

  button_channel #(
    .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
    .REPEAT_ENABLE       (AutoRepeat),
    .ACTIVE_LOW          (BUTTON_ACTIVE_LOW)
  ) u_inc (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (butt_increase),
    .pulse  (inc_raw)
  );

  button_channel #(
    .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
    .REPEAT_ENABLE       (AutoRepeat),
    .ACTIVE_LOW          (BUTTON_ACTIVE_LOW)
  ) u_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (butt_decrease),
    .pulse  (dec_raw)
  );

  button_channel #(
    .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
    .REPEAT_ENABLE       (1'b0),
    .ACTIVE_LOW          (BUTTON_ACTIVE_LOW)
  ) u_chg (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (butt_change),
    .pulse  (chg_raw)
  );

  field_t field_q, field_d;
  logic   inc_q, inc_d;
  logic   dec_q, dec_d;
  logic   chg_q, chg_d;
  logic   editing;

  always_comb begin
    field_d = field_q;
    chg_d   = chg_raw;
    if (chg_raw) begin
      field_d = (field_q == LastField) ? FIELD_RUN : field_t'(field_q + 3'd1);
    end
    // Qualify with the pre-advance field; coincident inc+dec cancel each other.
    editing = (field_q != FIELD_RUN);
    inc_d   = inc_raw & ~dec_raw & editing;
    dec_d   = dec_raw & ~inc_raw & editing;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_q <= FIELD_RUN;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      field_q <= field_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      chg_q   <= chg_d;
    end
  end

  assign inc_pulse   = inc_q;
  assign dec_pulse   = dec_q;
  assign chg_pulse   = chg_q;
  assign field_sel   = field_q;
  assign edit_active = (field_q != FIELD_RUN);

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Dly  = 10;
  localparam int unsigned Rate = 3;
  localparam int unsigned Lat  = Deb + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b_inc = 1'b1;
  logic       b_dec = 1'b1;
  logic       b_chg = 1'b1;
  logic       inc_pulse, dec_pulse, chg_pulse, edit_active;
  logic [2:0] field_sel;

  button_conditioner #(
    .DEBOUNCE_CYCLES     (Deb),
    .REPEAT_DELAY_CYCLES (Dly),
    .REPEAT_RATE_CYCLES  (Rate),
    .NUM_FIELDS          (7),
    .BUTTON_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .butt_increase (b_inc),
    .butt_decrease (b_dec),
    .butt_change   (b_chg),
    .inc_pulse     (inc_pulse),
    .dec_pulse     (dec_pulse),
    .chg_pulse     (chg_pulse),
    .field_sel     (field_sel),
    .edit_active   (edit_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected pulse event: sample cycle, which pulses, field_sel seen at that cycle.
  typedef struct {
    int         at;
    logic       inc;
    logic       dec;
    logic       chg;
    logic [2:0] field;
  } ev_t;
  ev_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ev(input int at, input logic i, input logic d, input logic c,
                           input logic [2:0] f);
    ev_t e;
    e.at = at; e.inc = i; e.dec = d; e.chg = c; e.field = f;
    sb.push_back(e);
  endtask

  task automatic drained(input string name);
    check({name, "_missing_pulses"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    if (inc_pulse || dec_pulse || chg_pulse) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", int'({inc_pulse, dec_pulse, chg_pulse}), 0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.at);
        check("pulse_kind", int'({inc_pulse, dec_pulse, chg_pulse}),
              int'({e.inc, e.dec, e.chg}));
        check("pulse_field", int'(field_sel), int'(e.field));
      end
    end
    if (edit_active !== (field_sel != 3'd0)) begin
      check("edit_active", int'(edit_active), int'(field_sel != 3'd0));
    end
  end

  typedef struct {
    string      name;
    logic       inc;
    logic       dec;
    logic       chg;
    logic       ei;
    logic       ed;
    logic       ec;
    logic [2:0] ef;
  } vec_t;
  vec_t vecs[13];

  initial begin
    int c0;
    int cr;

    vecs[0]  = '{"inc_in_run",  1, 0, 0, 0, 0, 0, 3'd0};
    vecs[1]  = '{"dec_in_run",  0, 1, 0, 0, 0, 0, 3'd0};
    vecs[2]  = '{"chg_to_1",    0, 0, 1, 0, 0, 1, 3'd1};
    vecs[3]  = '{"inc_f1",      1, 0, 0, 1, 0, 0, 3'd1};
    vecs[4]  = '{"dec_f1",      0, 1, 0, 0, 1, 0, 3'd1};
    vecs[5]  = '{"chg_to_2",    0, 0, 1, 0, 0, 1, 3'd2};
    vecs[6]  = '{"chg_to_3",    0, 0, 1, 0, 0, 1, 3'd3};
    vecs[7]  = '{"incdec_f3",   1, 1, 0, 0, 0, 0, 3'd3};
    vecs[8]  = '{"chg_inc_f3",  1, 0, 1, 1, 0, 1, 3'd4};
    vecs[9]  = '{"chg_to_5",    0, 0, 1, 0, 0, 1, 3'd5};
    vecs[10] = '{"chg_to_6",    0, 0, 1, 0, 0, 1, 3'd6};
    vecs[11] = '{"chg_wrap_0",  0, 0, 1, 0, 0, 1, 3'd0};
    vecs[12] = '{"chg_dec_run", 0, 1, 1, 0, 0, 1, 3'd1};

    // Reset, all released.
    tick(3);
    check("rst_field", int'(field_sel), 0);
    check("rst_pulses", int'({inc_pulse, dec_pulse, chg_pulse, edit_active}), 0);
    rst_n = 1'b1;
    tick(50);
    check("idle50_field", int'(field_sel), 0);
    drained("idle50");

    // Single presses from the table.
    for (int i = 0; i < 13; i++) begin
      c0 = cyc;
      b_inc = ~vecs[i].inc;
      b_dec = ~vecs[i].dec;
      b_chg = ~vecs[i].chg;
      if (vecs[i].ei || vecs[i].ed || vecs[i].ec)
        expect_ev(c0 + Lat, vecs[i].ei, vecs[i].ed, vecs[i].ec, vecs[i].ef);
      tick(8);
      b_inc = 1'b1; b_dec = 1'b1; b_chg = 1'b1;
      tick(20);
      check({vecs[i].name, "_field"}, int'(field_sel), int'(vecs[i].ef));
      drained(vecs[i].name);
    end

    // Bounce on increase (field 1), then a clean hold.
    for (int i = 0; i < 10; i++) begin
      b_inc = (i % 2 == 1);
      tick(2);
    end
    b_inc = 1'b0;
    c0 = cyc;
    expect_ev(c0 + Lat, 1, 0, 0, 3'd1);
    tick(8);
    b_inc = 1'b1;
    tick(20);
    drained("bounce");

    // Hold increase for 40 cycles.
    b_inc = 1'b0;
    c0 = cyc;
    expect_ev(c0 + 6, 1, 0, 0, 3'd1);
`ifdef BTN_AUTO_REPEAT_EN
    expect_ev(c0 + 16, 1, 0, 0, 3'd1);
    for (int k = 19; k < 46; k += 3) expect_ev(c0 + k, 1, 0, 0, 3'd1);
`endif
    tick(40);
    b_inc = 1'b1;
    tick(20);
    drained("hold40");

    // Hold decrease, reset mid-repeat; hold change through the reset as well.
    b_dec = 1'b0;
    c0 = cyc;
    expect_ev(c0 + 6, 0, 1, 0, 3'd1);
`ifdef BTN_AUTO_REPEAT_EN
    expect_ev(c0 + 16, 0, 1, 0, 3'd1);
    expect_ev(c0 + 19, 0, 1, 0, 3'd1);
`endif
    tick(20);
    rst_n = 1'b0;
    #1;
    check("midrst_field", int'(field_sel), 0);
    check("midrst_pulses", int'({inc_pulse, dec_pulse, chg_pulse, edit_active}), 0);
    drained("pre_reset");
    b_chg = 1'b0;
    tick(3);
    rst_n = 1'b1;
    cr = cyc;
    // Both held buttons are new presses at cr+6; dec is qualified by the pre-advance RUN.
    expect_ev(cr + Lat, 0, 0, 1, 3'd1);
`ifdef BTN_AUTO_REPEAT_EN
    expect_ev(cr + 16, 0, 1, 0, 3'd1);
    expect_ev(cr + 19, 0, 1, 0, 3'd1);
    expect_ev(cr + 22, 0, 1, 0, 3'd1);
`endif
    tick(5);
    check("postrst_field_before_accept", int'(field_sel), 0);
    tick(13);
    b_dec = 1'b1;
    b_chg = 1'b1;
    tick(20);
    check("postrst_field", int'(field_sel), 1);
    drained("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
